// File: rtl/lpm_1_fixed_mul.sv
// Two-stage pipelined 32x32 unsigned multiplier returning the low 32 bits of the product.
// Stage 1 registers 16x16 partial products; stage 2 sums them into the result.
module lpm_1_fixed_mul #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             out_valid,
    output logic [WIDTH-1:0] result
);

    generate
        if (WIDTH != 32 || LATENCY != 2) begin : g_bad_param
            $error("lpm_1_fixed_mul supports only WIDTH=32 and LATENCY=2");
        end
    endgenerate

    logic [15:0] a_l, a_h, b_l, b_h;

    logic [31:0] p_ll_d, p_ll_q;
    logic [15:0] p_lh_d, p_lh_q;
    logic [15:0] p_hl_d, p_hl_q;
    logic        v1_d, v1_q;

    logic [15:0] cross_sum;
    logic [31:0] result_d, result_q;
    logic        out_valid_d, out_valid_q;

    assign a_l = dataa[15:0];
    assign a_h = dataa[31:16];
    assign b_l = datab[15:0];
    assign b_h = datab[31:16];

    // Stage 1: aH*bH only reaches bits 63:32, so it is never formed.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        p_ll_d = p_ll_q;
        p_lh_d = p_lh_q;
        p_hl_d = p_hl_q;
        v1_d   = in_valid;
        if (in_valid) begin
            p_ll_d = {16'h0, a_l} * {16'h0, b_l};
            p_lh_d = a_l * b_h;
            p_hl_d = a_h * b_l;
        end
    end

    // Stage 2: cross terms only matter modulo 2^16 once shifted up by 16.
    always_comb begin
        cross_sum   = p_lh_q + p_hl_q;
        result_d    = result_q;
        out_valid_d = v1_q;
        if (v1_q) begin
            result_d = p_ll_q + {cross_sum, 16'h0};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_ll_q      <= '0;
            p_lh_q      <= '0;
            p_hl_q      <= '0;
            v1_q        <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_ll_q      <= p_ll_d;
            p_lh_q      <= p_lh_d;
            p_hl_q      <= p_hl_d;
            v1_q        <= v1_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_lpm_1_fixed_mul.sv
// Scoreboard bench for lpm_1_fixed_mul: stimulus pushes expected products,
// a negedge monitor pops and checks value, order, latency and output hold.
module tb_lpm_1_fixed_mul;

    typedef struct {
        logic [31:0] res;
        int          issue_edge;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        out_valid;
    logic [31:0] result;

    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];
    logic [31:0] sb_last;

    lpm_1_fixed_mul #(.WIDTH(32), .LATENCY(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .dataa     (dataa),
        .datab     (datab),
        .out_valid (out_valid),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on every valid output, otherwise checks the held value.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result", result, e.res);
                    check("latency", cyc, e.issue_edge + 1);
                    sb_last = e.res;
                end
            end else begin
                check("hold", result, sb_last);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        dataa    = a;
        datab    = b;
        e.res        = exp;
        e.issue_edge = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        dataa    = 'x;
        datab    = 'x;
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;
        sb_last  = 32'h0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        dataa    = 32'h0;
        datab    = 32'h0;

        #1;
        check("reset_out_valid", {31'h0, out_valid}, 32'd0);
        check("reset_result", result, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Basic back-to-back sequence
        issue(32'd1, 32'd2, 32'd2);
        issue(32'd332, 32'd22, 32'd7304);
        issue(32'd2, 32'd23, 32'd46);
        idle();

        // Wrap-around and cross terms
        issue(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        issue(32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(32'h0001_FFFF, 32'h0001_FFFF, 32'hFFFC_0001);
        issue(32'h1234_5678, 32'h0, 32'h0);
        issue(32'h0001_0001, 32'h0003_0005, 32'h0008_0005);
        idle();
        idle();

        // Bubble: result must hold 15 through the gap
        issue(32'd3, 32'd5, 32'd15);
        idle();
        issue(32'd7, 32'd9, 32'd63);
        idle();
        idle();

        // Mid-stream reset: opA visible, op1 in stage 1, op2 on the inputs
        issue(32'd10, 32'd11, 32'd110);
        issue(32'd12, 32'd13, 32'd156);
        issue(32'd14, 32'd15, 32'd210);
        #2;
        check("pre_reset_valid", {31'h0, out_valid}, 32'd1);
        reset_n = 1'b0;
        sb_q.delete();
        sb_last = 32'h0;
        #1;
        check("async_reset_valid", {31'h0, out_valid}, 32'd0);
        check("async_reset_result", result, 32'h0);
        idle();
        idle();
        check("in_reset_valid", {31'h0, out_valid}, 32'd0);
        reset_n = 1'b1;
        idle();
        idle();
        idle();

        // Random pairs with random in_valid
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a, b, p;
            logic        v;
            a = $urandom;
            b = $urandom;
            v = 1'($urandom_range(0, 1));
            p = a * b;
            if (v) begin
                issue(a, b, p);
            end else begin
                @(negedge clk);
                in_valid = 1'b0;
                dataa    = a;
                datab    = b;
            end
        end
        idle();

        // Bounded drain
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) begin
            idle();
        end
        idle();
        check("drain_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
